seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal values are powers of two, 8 to 64.
REQ-002 Parameter STEP, default 1, maximum bit positions shifted per BUSY cycle; legal values are powers of two, 1 to WIDTH.
REQ-003 Localparam SHW = log2(WIDTH), shift-amount width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 in_a  input  WIDTH  operand.
REQ-009 in_amt  input  SHW  shift amount.
REQ-010 in_funct  input  2  00 logical right, 01 logical left, 10 arithmetic right, 11 rotate right.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_res  output  WIDTH  result.

Function
REQ-014 States: IDLE, BUSY and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 IDLE with in_valid = 1 shall capture in_a, in_amt and in_funct at the clock edge; the next state is DONE if in_amt = 0, else BUSY.
REQ-016 Each BUSY cycle shall shift the working register by k = min(STEP, remaining) positions in the captured mode and decrement remaining by k.
REQ-017 BUSY shall go to DONE on the edge where remaining becomes 0; BUSY occupancy is ceil(in_amt/STEP) cycles.
REQ-018 Latency from the accepting edge to out_valid high is 1 + ceil(in_amt/STEP) edges, minus 1 if in_amt = 0, i.e. exactly 1 edge for amt = 0.
REQ-019 Logical shifts shall fill with 0; arithmetic right shall fill with the operand's bit WIDTH-1; rotate right shall move bit 0 into bit WIDTH-1.
REQ-020 DONE shall hold out_res stable until out_valid and out_ready are both 1, then go to IDLE on that edge.
REQ-021 Back-to-back operation: a new request is accepted no earlier than the cycle after result handoff; in_valid outside IDLE shall be ignored with no state change.
REQ-022 out_res shall equal the working register in every state; its value is defined only while out_valid = 1.
REQ-023 in_amt greater than or equal to WIDTH is unrepresentable; in_amt = WIDTH-1 shall be legal for all modes.

Reset
REQ-024 rst = 1 shall immediately force IDLE, in_ready = 1, out_valid = 0, out_res = 0, remaining = 0 and the captured funct to 00, regardless of clock.
REQ-025 Reset asserted during BUSY or DONE shall abandon the operation with no result produced; the first edge after deassertion behaves as IDLE.

Configuration
REQ-026 Macro SEQ_SHIFTER_ROTATE_EN: when defined, funct 11 performs rotate right per REQ-019.
REQ-027 When SEQ_SHIFTER_ROTATE_EN is undefined, funct 11 shall perform logical right (identical to 00); no rotate logic shall be synthesised, and latency is unchanged.

Verification
REQ-028 WIDTH=32, STEP=1, in_a=0x8000_0001, funct 00, amt 4 -> out_valid 5 edges after accept, out_res=0x0800_0000.
REQ-029 WIDTH=32, STEP=4, in_a=0xF000_0000, funct 10, amt 9 -> 3 BUSY cycles, out_res=0xFFF8_0000.
REQ-030 ROTATE_EN defined, in_a=0x0000_0003, funct 11, amt 1 -> 0x8000_0001; macro undefined -> 0x0000_0001.
REQ-031 funct 01, amt 0, in_a=0x1234_5678 -> out_valid 1 edge after accept, out_res=0x1234_5678; out_ready held 0 for 3 cycles -> out_res and out_valid stable, in_ready=0.
REQ-032 rst pulsed mid-BUSY (amt 20, STEP 1, cycle 5) -> outputs take reset values without a clock edge; next request completes correctly.
REQ-033 in_valid held high continuously with out_ready=1 -> exactly one acceptance per IDLE visit; no requests are accepted in BUSY or DONE.

Source files
------------

// File: rtl/seq_shifter_if.sv
// seq_shifter_if -- request/result handshake bundle for seq_shifter.
//   master : drives in_valid/in_a/in_amt/in_funct and out_ready,
//            observes in_ready/out_valid/out_res (the requester/consumer side)
//   slave  : the shifter side (mirror of master)
// WIDTH must match the seq_shifter instance it connects to; SHW = log2(WIDTH).
interface seq_shifter_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_funct;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;

  modport master (
    output in_valid, in_a, in_amt, in_funct, out_ready,
    input  in_ready, out_valid, out_res
  );

  modport slave (
    input  in_valid, in_a, in_amt, in_funct, out_ready,
    output in_ready, out_valid, out_res
  );
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter -- multi-cycle barrel-less shifter, up to STEP positions per cycle.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   bus.slave  : in_valid/in_ready/in_a/in_amt/in_funct request handshake,
//                out_valid/out_ready/out_res result handshake
//   in_funct   : 00 logical right, 01 logical left, 10 arithmetic right,
//                11 rotate right (SEQ_SHIFTER_ROTATE_EN defined) or
//                logical right (macro undefined)
// Parameters: WIDTH (power of two, 8..64), STEP (power of two, 1..WIDTH).
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic          clk,
  input logic          rst,
  seq_shifter_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  // remaining never exceeds WIDTH-1, so clamping STEP there keeps
  // min(STEP, remaining) unchanged while letting it fit in SHW bits.
  localparam int unsigned    STEP_C = (STEP < WIDTH) ? STEP : WIDTH - 1;
  localparam logic [SHW-1:0] STEP_V = SHW'(STEP_C);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] work, work_n, shifted;
  logic [SHW-1:0]   rem, rem_n, k;
  logic [1:0]       funct, funct_n;

  // Shift distance for this BUSY cycle.
  always_comb k = (rem > STEP_V) ? STEP_V : rem;

`ifdef SEQ_SHIFTER_ROTATE_EN
  // Rotating the doubled word right leaves the rotated value in the low half.
  logic [2*WIDTH-1:0] rot_full;
  always_comb rot_full = {work, work} >> k;
`endif

  always_comb begin
    shifted = work >> k;
    case (funct)
      2'b01:   shifted = work << k;
      // Working MSB is the operand MSB, and stays so across arithmetic steps.
      2'b10:   shifted = $signed(work) >>> k;
`ifdef SEQ_SHIFTER_ROTATE_EN
      2'b11:   shifted = rot_full[WIDTH-1:0];
`endif
      default: shifted = work >> k;
    endcase
  end

  always_comb begin
    state_n = state;
    work_n  = work;
    rem_n   = rem;
    funct_n = funct;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          work_n  = bus.in_a;
          rem_n   = bus.in_amt;
          funct_n = bus.in_funct;
          state_n = (bus.in_amt == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        work_n = shifted;
        rem_n  = rem - k;
        if (rem == k) state_n = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
      funct <= '0;
    end else begin
      state <= state_n;
      work  <= work_n;
      rem   <= rem_n;
      funct <= funct_n;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_res   = work;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter -- directed bench for seq_shifter. Two instances (STEP=1 and
// STEP=4, WIDTH=32) share one stimulus stream; each has its own scoreboard
// queue filled from a bit-serial reference model.
module tb_seq_shifter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, out_ready;
  logic [W-1:0] in_a;
  logic [4:0]   in_amt;
  logic [1:0]   in_funct;

  seq_shifter_if #(.WIDTH(W)) bus1 ();
  seq_shifter_if #(.WIDTH(W)) bus4 ();

  seq_shifter #(.WIDTH(W), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  seq_shifter #(.WIDTH(W), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus1.in_valid  = in_valid;
  assign bus1.in_a      = in_a;
  assign bus1.in_amt    = in_amt;
  assign bus1.in_funct  = in_funct;
  assign bus1.out_ready = out_ready;
  assign bus4.in_valid  = in_valid;
  assign bus4.in_a      = in_a;
  assign bus4.in_amt    = in_amt;
  assign bus4.in_funct  = in_funct;
  assign bus4.out_ready = out_ready;

  logic [1:0]   rdy, ov;
  logic [W-1:0] res [2];
  assign rdy    = {bus4.in_ready, bus1.in_ready};
  assign ov     = {bus4.out_valid, bus1.out_valid};
  assign res[0] = bus1.out_res;
  assign res[1] = bus4.out_res;

  int errors = 0;
  int checks = 0;
  int opn    = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int exp_lat(input int amt, input int step);
    return (amt == 0) ? 1 : 1 + (amt + step - 1) / step;
  endfunction

  // One bit position per iteration, independent of the DUT's chunking.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input int amt,
                                         input logic [1:0] f);
    logic [W-1:0] r;
    r = a;
    for (int i = 0; i < amt; i++) begin
      case (f)
        2'b00: r = {1'b0, r[W-1:1]};
        2'b01: r = {r[W-2:0], 1'b0};
        2'b10: r = {r[W-1], r[W-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
        default: r = {r[0], r[W-1:1]};
`else
        default: r = {1'b0, r[W-1:1]};
`endif
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_both(input logic [W-1:0] e);
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic pop_check(input int i, input string tag);
    logic [W-1:0] e;
    int sz;
    sz = (i == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty, observed=%0h", tag, res[i]);
    end else begin
      e = (i == 0) ? q0.pop_front() : q1.pop_front();
      check(tag, res[i], e);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input int amt, input logic [1:0] f);
    logic [1:0] done;
    int lat;
    opn++;
    @(negedge clk);
    check($sformatf("ready_op%0d", opn), rdy, 2'b11);
    in_a      = a;
    in_amt    = 5'(amt);
    in_funct  = f;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    push_both(model(a, amt, f));
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat  = 1;
    done = 2'b00;
    for (int n = 0; n < 80 && done != 2'b11; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!done[i] && ov[i]) begin
          check($sformatf("lat_s%0d_op%0d", step_of(i), opn), lat, exp_lat(amt, step_of(i)));
          pop_check(i, $sformatf("res_s%0d_op%0d", step_of(i), opn));
          done[i] = 1'b1;
        end
      end
      if (done != 2'b11) begin
        @(posedge clk);
        #1 lat++;
      end
    end
    if (done != 2'b11) begin
      checks++;
      errors++;
      $display("FAIL timeout_op%0d done=%b required=11", opn, done);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[2];
    int hand[2];
    logic [W-1:0] e;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_amt = '0; in_funct = '0;
    #12;
    check("rst_ready", rdy, 2'b11);
    check("rst_valid", ov, 2'b00);
    check("rst_res1", res[0], '0);
    check("rst_res4", res[1], '0);
    @(negedge clk) rst = 1'b0;

    // Reference vectors and boundary amounts.
    run_op(32'h8000_0001, 4, 2'b00);
    run_op(32'hF000_0000, 9, 2'b10);
    run_op(32'h0000_0003, 1, 2'b11);
    for (int f = 0; f < 4; f++) run_op(32'h9ABC_DEF1, W - 1, 2'(f));
    for (int t = 0; t < 6; t++)
      run_op($urandom, $urandom_range(0, W - 1), 2'($urandom_range(0, 3)));

    // amt 0 with consumer stalled; in_valid during DONE must be ignored.
    @(negedge clk);
    in_a = 32'h1234_5678; in_amt = '0; in_funct = 2'b01;
    in_valid = 1'b1; out_ready = 1'b0;
    push_both(32'h1234_5678);
    @(posedge clk);
    #1 check("amt0_lat1", ov, 2'b11);
    in_a = 32'hDEAD_BEEF; in_amt = 5'd5;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall_valid%0d", c), ov, 2'b11);
      check($sformatf("stall_ready%0d", c), rdy, 2'b00);
      check($sformatf("stall_res1_%0d", c), res[0], 32'h1234_5678);
      check($sformatf("stall_res4_%0d", c), res[1], 32'h1234_5678);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    pop_check(0, "stall_pop1");
    pop_check(1, "stall_pop4");
    @(posedge clk);
    #1;
    check("stall_release_ready", rdy, 2'b11);
    check("stall_release_valid", ov, 2'b00);

    // Reset mid-BUSY, between clock edges.
    @(negedge clk);
    in_a = 32'hFFFF_0000; in_amt = 5'd20; in_funct = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", rdy, 2'b11);
    check("midrst_valid", ov, 2'b00);
    check("midrst_res1", res[0], '0);
    check("midrst_res4", res[1], '0);
    @(negedge clk) rst = 1'b0;
    run_op(32'h0F0F_0F0F, 20, 2'b10);

    // in_valid held high: one acceptance per IDLE visit.
    acc  = '{0, 0};
    hand = '{0, 0};
    @(negedge clk);
    in_a = 32'hA5A5_A5A5; in_amt = 5'd3; in_funct = 2'b00;
    in_valid = 1'b1; out_ready = 1'b1;
    e = model(32'hA5A5_A5A5, 3, 2'b00);
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (rdy[i]) begin
          acc[i]++;
          if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (ov[i]) begin
          hand[i]++;
          pop_check(i, $sformatf("stream_s%0d_%0d", step_of(i), hand[i]));
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (ov[i]) begin
          hand[i]++;
          pop_check(i, $sformatf("stream_s%0d_%0d", step_of(i), hand[i]));
        end
      end
      @(negedge clk);
    end
    check("stream_acc1", acc[0], 6);
    check("stream_acc4", acc[1], 10);
    check("stream_hand1", hand[0], acc[0]);
    check("stream_hand4", hand[1], acc[1]);
    check("stream_q_empty", q0.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
